mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised, registered N-channel, W-bit multiplexer, the successor to the team's fixed 8-to-1 single-bit mux. It supports a manual mode, where the channel comes from `sel`, and a scan mode, where the block round-robins over the channels enabled in a mask. The selected word and its channel number are presented through a valid/ready output register. It sits between a bank of sampled sources and a single downstream consumer, such as a serializer or logger.

## Interface
- `N_CH`, default 8: number of input channels, at least 2; need not be a power of two.
- `WIDTH`, default 8: bits per channel.
- `SEL_W`, localparam equal to `$clog2(N_CH)`: width of the select and channel fields.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `in_bus`, input, `N_CH*WIDTH`: channel k occupies `[k*WIDTH +: WIDTH]`.
- `sel`, input, `SEL_W`: channel select, used in manual mode.
- `mode`, input, 1: 0 selects MANUAL, 1 selects SCAN.
- `ch_mask`, input, `N_CH`: bit k=1 enables channel k in scan mode; ignored in manual mode.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.
- `out_data`, output, `WIDTH`: registered selected word.
- `out_ch`, output, `SEL_W`: channel index that `out_data` came from.
- `out_valid`, output, 1: `out_data` and `out_ch` hold an unconsumed word.

## Operation
- Load condition: `load = !out_valid || out_ready`. The output register is written only on cycles where `load` is true; otherwise it holds.
- MANUAL mode, on `load`:
  - `out_data <= in_bus[sel]`, `out_ch <= sel`, `out_valid <= 1`.
  - If `sel >= N_CH`: `out_data <= 0`, `out_ch <= sel`, `out_valid <= 1`.
- SCAN mode, on `load`:
  - Search `ch_mask` circularly, starting at pointer `ptr`, for the first set bit c.
  - If c is found: `out_data <= in_bus[c]`, `out_ch <= c`, `out_valid <= 1`.
  - Pointer update: `ptr <= c+1`, wrapping from `N_CH-1` to 0.
  - If `ch_mask` is all zero: `out_valid <= 0`, and `out_data`, `out_ch` and `ptr` hold.
- `ptr` advances only on a scan-mode load that finds a channel; manual-mode loads do not touch it.
- Mode change MANUAL to SCAN, detected as `mode` going to 1 while the registered previous mode was 0: `ptr` is forced to 0 for that cycle's search.
- Mode change SCAN to MANUAL: takes effect on the next `load`; no flush.
- A word already held with `out_valid=1 && out_ready=0` is never overwritten, regardless of changes to `mode`, `sel`, `ch_mask` or `in_bus`.
- `ch_mask` changes take effect at the next search. A held word from a now-disabled channel is still delivered.

## Timing
- Reset values: `out_data=0`, `out_ch=0`, `out_valid=0`, `ptr=0`, registered previous mode = MANUAL.
- Latency: the input sampled on a `load` edge appears one cycle later. There is no combinational path from `in_bus`, `sel`, `mode` or `ch_mask` to any output.
- Throughput: one word per cycle while `out_ready=1`.
- Back-pressure: while `out_valid=1 && out_ready=0`, all outputs and `ptr` are stable.
- Simultaneous handshake and load: on a cycle with `out_valid=1 && out_ready=1`, the current word is consumed and the next word loads on the same edge.
- `out_ready` is honoured even when `out_valid=0`, because `load` is already true.
- Reset asserted mid-stream: on that edge, all state returns to reset values and any held word is discarded. The first load occurs on the first edge with `reset=0`.
- Wrap-around: with only channel `N_CH-1` and channel 0 enabled, the output alternates between them.

## Structure
- Package `mux_pkg`:
  - `MODE_MANUAL`/`MODE_SCAN` constants, as a 1-bit enum.
  - Default `N_CH`/`WIDTH` constants.
- Sub-module `mux_rr_pick`:
  - Combinational circular first-set search over `ch_mask` from `ptr`.
  - Outputs `found` (1 bit) and `idx` (`SEL_W`).
  - Instantiated once; unit-testable on its own.
- Top level holds the output register, `ptr`, the previous-mode register and the load logic.

## Test plan
Defaults `N_CH=8`, `WIDTH=8`; channel k drives `8'h10+k`.
- Manual: reset, `mode=0`, `out_ready=1`, step `sel` through 0..7 → one cycle later `out_data=8'h10..8'h17` in order, with `out_ch` matching and `out_valid=1` every cycle.
- Scan with mask: `mode=1`, `ch_mask=8'b1000_0101`, `out_ready=1` → `out_ch` sequence 0,2,7,0,2,7…, with data `8'h10, 8'h12, 8'h17`.
- Back-pressure: scan, all channels enabled, `out_ready=0` for 5 cycles after the first valid → `out_ch=0` and `out_data=8'h10` held; on release, the next words are channels 1 and 2 with nothing skipped.
- Empty mask: scan with `ch_mask=0` → `out_valid` drops after the held word is consumed and `ptr` is unchanged. Then set `ch_mask=8'h08` → `out_ch=3` on every subsequent word.
- Mode switch and reset:
  - Scan to channel 5, switch to manual with `sel=1` → next word from channel 1.
  - Switch back to scan → next word from channel 0.
  - Assert `reset` mid-stream → the next cycle shows all outputs 0.
- Out-of-range select: `N_CH=6`, manual, `sel=7` → `out_data=0`, `out_ch=7`, `out_valid=1`.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared mode encoding and default sizing for the scanning output mux.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int DEF_N_CH  = 8;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/mux_rr_pick.sv
// Circular first-set search over a channel mask, starting at ptr.
module mux_rr_pick #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_CH-1:0]  mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    int c;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            c = int'(ptr) + i;
            if (c >= N_CH) c = c - N_CH;
            if (mask[c]) begin
                found = 1'b1;
                idx   = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel mux with manual select or round-robin scan, behind a valid/ready output register.
module mux_scan
    import mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid
);

    logic [SEL_W-1:0] ptr;
    logic             mode_prev;
    logic [SEL_W-1:0] search_ptr;
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] man_data;
    logic [WIDTH-1:0] scan_data;
    logic             load;

    assign load = !out_valid || out_ready;

    // Entering scan mode restarts the search at channel 0.
    assign search_ptr = (mode == MODE_SCAN && mode_prev == MODE_MANUAL) ? '0 : ptr;

    mux_rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
        .ptr   (search_ptr),
        .mask  (ch_mask),
        .found (found),
        .idx   (idx)
    );

    // Compare-based muxes so an out-of-range select yields zero instead of an out-of-bounds slice.
    always_comb begin
        man_data  = '0;
        scan_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) man_data  = in_bus[k*WIDTH +: WIDTH];
            if (idx == SEL_W'(k)) scan_data = in_bus[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            mode_prev <= MODE_MANUAL;
        end else begin
            mode_prev <= mode;
            if (load) begin
                if (mode == MODE_MANUAL) begin
                    out_data  <= man_data;
                    out_ch    <= sel;
                    out_valid <= 1'b1;
                end else if (found) begin
                    out_data  <= scan_data;
                    out_ch    <= idx;
                    out_valid <= 1'b1;
                    ptr       <= (idx == SEL_W'(N_CH - 1)) ? '0 : idx + 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: manual, masked scan, back-pressure, empty mask, mode switch, reset, out-of-range select.
module tb_mux_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_bus;
    logic [2:0]  sel;
    logic        mode;
    logic [7:0]  ch_mask;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;

    logic [47:0] in_bus2;
    logic [2:0]  sel2;
    logic [5:0]  ch_mask2;
    logic        out_ready2;
    logic [7:0]  out_data2;
    logic [2:0]  out_ch2;
    logic        out_valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan #(.N_CH(8), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus),
        .sel       (sel),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid)
    );

    mux_scan #(.N_CH(6), .WIDTH(8)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus2),
        .sel       (sel2),
        .mode      (1'b0),
        .ch_mask   (ch_mask2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .out_ch    (out_ch2),
        .out_valid (out_valid2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input int ch, input logic [7:0] data, input logic vld);
        check({tag, ".ch"},    32'(out_ch),    32'(ch));
        check({tag, ".data"},  32'(out_data),  32'(data));
        check({tag, ".valid"}, 32'(out_valid), 32'(vld));
    endtask

    initial begin
        int scan_seq[3];
        scan_seq = '{0, 2, 7};
        for (int k = 0; k < 8; k++) in_bus[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 6; k++) in_bus2[k*8 +: 8] = 8'h20 + 8'(k);
        reset = 1'b1; sel = 3'd0; mode = 1'b0; ch_mask = 8'h00; out_ready = 1'b1;
        sel2 = 3'd0; ch_mask2 = 6'h00; out_ready2 = 1'b1;

        // Reset state
        step();
        step();
        expect_word("reset", 0, 8'h00, 1'b0);
        reset = 1'b0;

        // Manual sweep
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            expect_word($sformatf("manual%0d", s), s, 8'h10 + 8'(s), 1'b1);
        end

        // Masked scan with wrap from 7 to 0
        mode = 1'b1; ch_mask = 8'b1000_0101;
        for (int i = 0; i < 6; i++) begin
            step();
            expect_word($sformatf("scan%0d", i), scan_seq[i % 3], 8'h10 + 8'(scan_seq[i % 3]), 1'b1);
        end

        // Back-pressure: hold channel 0 for 5 cycles, then 1 and 2 without skipping
        ch_mask = 8'hFF;
        step();
        expect_word("bp_first", 0, 8'h10, 1'b1);
        out_ready = 1'b0;
        ch_mask = 8'h00; sel = 3'd6; in_bus[7:0] = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_word($sformatf("bp_hold%0d", i), 0, 8'h10, 1'b1);
        end
        in_bus[7:0] = 8'h10; ch_mask = 8'hFF; out_ready = 1'b1;
        step();
        expect_word("bp_rel1", 1, 8'h11, 1'b1);
        step();
        expect_word("bp_rel2", 2, 8'h12, 1'b1);

        // Empty mask drops valid, keeps data/ch, leaves ptr at 3
        ch_mask = 8'h00;
        step();
        expect_word("empty0", 2, 8'h12, 1'b0);
        step();
        expect_word("empty1", 2, 8'h12, 1'b0);
        ch_mask = 8'hFF;
        step();
        expect_word("ptr_kept", 3, 8'h13, 1'b1);
        ch_mask = 8'h08;
        step();
        expect_word("only3_a", 3, 8'h13, 1'b1);
        step();
        expect_word("only3_b", 3, 8'h13, 1'b1);

        // Mode switches
        ch_mask = 8'hFF;
        step();
        expect_word("scan4", 4, 8'h14, 1'b1);
        step();
        expect_word("scan5", 5, 8'h15, 1'b1);
        mode = 1'b0; sel = 3'd1;
        step();
        expect_word("to_manual", 1, 8'h11, 1'b1);
        mode = 1'b1;
        step();
        expect_word("to_scan", 0, 8'h10, 1'b1);
        step();
        expect_word("scan_after", 1, 8'h11, 1'b1);

        // Reset mid-stream
        reset = 1'b1;
        step();
        expect_word("mid_reset", 0, 8'h00, 1'b0);
        reset = 1'b0;
        step();
        expect_word("post_reset", 0, 8'h10, 1'b1);

        // Six-channel instance: in-range and out-of-range select
        sel2 = 3'd5;
        step();
        check("n6_sel5.data",  32'(out_data2),  32'h25);
        check("n6_sel5.ch",    32'(out_ch2),    32'd5);
        sel2 = 3'd7;
        step();
        check("n6_sel7.data",  32'(out_data2),  32'h00);
        check("n6_sel7.ch",    32'(out_ch2),    32'd7);
        check("n6_sel7.valid", 32'(out_valid2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
